// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU width, opcode and arbiter state types
package alu_pkg;
  localparam int ALU_W = 8;
  typedef enum logic [1:0] {ALU_ADD = 2'b00, ALU_SUB = 2'b01, ALU_AND = 2'b10, ALU_OR = 2'b11} alu_op_t;
  typedef enum logic [1:0] {IDLE, EXEC, RESP} arb_state_t;
endpackage

// File: rtl/alu.sv
// alu: 8-bit add/sub/and/or unit with zero flag
module alu
  import alu_pkg::*;
(
  input  logic [ALU_W-1:0] SrcA,
  input  logic [ALU_W-1:0] SrcB,
  input  logic [1:0]       ALUControl,
  output logic [ALU_W-1:0] ALUResult,
  output logic             Zero
);
  // select the operation; add/sub wrap modulo 2^ALU_W
  always_comb
    ALUResult = ALUControl == ALU_ADD ? SrcA + SrcB :
                ALUControl == ALU_SUB ? SrcA - SrcB :
                ALUControl == ALU_AND ? SrcA & SrcB : SrcA | SrcB;
  assign Zero = ALUResult == '0;
endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, searching upward from ptr+1 modulo N
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);
  // later writes win: wrapped group (i<=ptr) first, then the preferred group (i>ptr); lowest index wins inside each
  always_comb begin
    gnt = '0;
    gnt_idx = '0;
    for (int i = N - 1; i >= 0; i--)
      if (req[i] && i <= int'(ptr)) begin
        gnt = '0;
        gnt[i] = 1'b1;
        gnt_idx = IW'(i);
      end
    for (int i = N - 1; i >= 0; i--)
      if (req[i] && i > int'(ptr)) begin
        gnt = '0;
        gnt[i] = 1'b1;
        gnt_idx = IW'(i);
      end
  end
endmodule

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one alu among NREQ requesters, one op in flight; ALU_SHARE_ARBITER_STATS_EN adds grant_cnt
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*ALU_W-1:0] req_a,
  input  logic [NREQ*ALU_W-1:0] req_b,
  input  logic [NREQ*2-1:0]     req_op,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [ALU_W-1:0]      rsp_result,
  output logic                  rsp_zero
`ifdef ALU_SHARE_ARBITER_STATS_EN
  ,
  output logic [NREQ*8-1:0]     grant_cnt
`endif
);
  arb_state_t state, nxt;
  logic [NREQ-1:0] gnt;
  logic [IDW-1:0] gnt_idx, rr_ptr, id_q;
  logic [ALU_W-1:0] a_q, b_q, alu_y;
  alu_op_t op_q;
  logic alu_z;
  logic [ALU_W-1:0] a_arr [NREQ];
  logic [ALU_W-1:0] b_arr [NREQ];
  logic [1:0] op_arr [NREQ];
  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign a_arr[g] = req_a[g*ALU_W +: ALU_W];
    assign b_arr[g] = req_b[g*ALU_W +: ALU_W];
    assign op_arr[g] = req_op[g*2 +: 2];
  end
  rr_arbiter #(.N(NREQ), .IW(IDW)) u_arb (.req(req_valid), .ptr(rr_ptr), .gnt(gnt), .gnt_idx(gnt_idx));
  alu u_alu (.SrcA(a_q), .SrcB(b_q), .ALUControl(op_q), .ALUResult(alu_y), .Zero(alu_z));
  // state register
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= nxt;
  // next state: accept in IDLE, one EXEC cycle, hold RESP until the consumer takes it
  always_comb
    nxt = state == IDLE ? (|req_valid ? EXEC : IDLE) :
          state == EXEC ? RESP : (rsp_ready ? IDLE : RESP);
  // grant is offered only while idle
  always_comb req_ready = state == IDLE ? gnt : '0;
  // capture winner operands, then latch the alu result into the response register
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      a_q <= '0;
      b_q <= '0;
      op_q <= ALU_ADD;
      id_q <= '0;
      rr_ptr <= IDW'(NREQ - 1);
      rsp_valid <= 1'b0;
      rsp_id <= '0;
      rsp_result <= '0;
      rsp_zero <= 1'b0;
    end else begin
      if (state == IDLE && |req_valid) begin
        a_q <= a_arr[gnt_idx];
        b_q <= b_arr[gnt_idx];
        op_q <= alu_op_t'(op_arr[gnt_idx]);
        id_q <= gnt_idx;
        rr_ptr <= gnt_idx;
      end
      if (state == EXEC) begin
        rsp_result <= alu_y;
        rsp_zero <= alu_z;
        rsp_id <= id_q;
        rsp_valid <= 1'b1;
      end
      if (state == RESP && rsp_ready) rsp_valid <= 1'b0;
    end
`ifdef ALU_SHARE_ARBITER_STATS_EN
  // per-requester saturating count of accepted requests
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) grant_cnt <= '0;
    else
      for (int i = 0; i < NREQ; i++)
        if (req_valid[i] && req_ready[i] && grant_cnt[i*8 +: 8] != 8'hFF)
          grant_cnt[i*8 +: 8] <= grant_cnt[i*8 +: 8] + 8'd1;
`else
  // no per-requester statistics in this build
`endif
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: table vectors plus scoreboard and hand sequences for alu_share_arbiter
module tb_alu_share_arbiter;
  localparam int N = 4;
  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic [N-1:0] req_valid, req_ready;
  logic [N*8-1:0] req_a, req_b;
  logic [N*2-1:0] req_op;
  logic rsp_valid, rsp_ready, rsp_zero;
  logic [1:0] rsp_id;
  logic [7:0] rsp_result;
`ifdef ALU_SHARE_ARBITER_STATS_EN
  logic [N*8-1:0] grant_cnt;
`endif

  alu_share_arbiter #(.NREQ(N)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_result(rsp_result), .rsp_zero(rsp_zero)
`ifdef ALU_SHARE_ARBITER_STATS_EN
    , .grant_cnt(grant_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { int id; logic [7:0] a; logic [7:0] b; logic [1:0] op; logic [7:0] res; logic z; } vec_t;
  typedef struct { int id; logic [7:0] res; logic z; } exp_t;

  vec_t vt[10];
  exp_t sb[$];
  exp_t mon_e;
  logic [8:0] mon_m;
  int acc_log[$];
  logic [7:0] rsp_log[$];
  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [8:0] model(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
    logic [7:0] r;
    case (op)
      2'b00: r = a + b;
      2'b01: r = a - b;
      2'b10: r = a & b;
      default: r = a | b;
    endcase
    return {r == 8'h00, r};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
    req_a[i*8 +: 8] = a;
    req_b[i*8 +: 8] = b;
    req_op[i*2 +: 2] = op;
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    #2 reset_n = 1'b0;
    @(negedge clk);
    #2 reset_n = 1'b1;
  endtask

  task automatic run_vec(input vec_t v);
    logic [N-1:0] oh;
    oh = '0;
    oh[v.id] = 1'b1;
    tick();
    req_valid = oh;
    set_req(v.id, v.a, v.b, v.op);
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("accept_ready", req_ready, oh);
    tick();
    req_valid = '0;
    @(negedge clk);
    chk("exec_no_rsp", rsp_valid, 0);
    @(negedge clk);
    chk("rsp_valid_t2", rsp_valid, 1);
    chk("rsp_id", rsp_id, v.id);
    chk("rsp_result", rsp_result, v.res);
    chk("rsp_zero", rsp_zero, v.z);
  endtask

  // scoreboard: push expected on request transfer, pop on response transfer
  always @(negedge clk) begin
    if (!reset_n) sb.delete();
    else begin
      chk("ready_onehot0", {31'b0, $onehot0(req_ready)}, 1);
      for (int i = 0; i < N; i++)
        if (req_valid[i] && req_ready[i]) begin
          mon_m = model(req_a[i*8 +: 8], req_b[i*8 +: 8], req_op[i*2 +: 2]);
          sb.push_back('{i, mon_m[7:0], mon_m[8]});
          acc_log.push_back(i);
        end
      if (rsp_valid && rsp_ready) begin
        rsp_log.push_back(rsp_result);
        if (sb.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL sb_unexpected: got response id %0d result %0h, expected none", rsp_id, rsp_result);
        end else begin
          mon_e = sb.pop_front();
          chk("sb_id", rsp_id, mon_e.id);
          chk("sb_result", rsp_result, mon_e.res);
          chk("sb_zero", rsp_zero, mon_e.z);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1);
  end

  initial begin
    vt[0] = '{0, 8'h05, 8'h0A, 2'b00, 8'h0F, 1'b0};
    vt[1] = '{2, 8'h05, 8'h05, 2'b01, 8'h00, 1'b1};
    vt[2] = '{1, 8'hFF, 8'h01, 2'b00, 8'h00, 1'b1};
    vt[3] = '{3, 8'h10, 8'h20, 2'b01, 8'hF0, 1'b0};
    vt[4] = '{0, 8'hF0, 8'h0F, 2'b10, 8'h00, 1'b1};
    vt[5] = '{1, 8'hA5, 8'h5A, 2'b11, 8'hFF, 1'b0};
    vt[6] = '{2, 8'hC3, 8'h81, 2'b10, 8'h81, 1'b0};
    vt[7] = '{3, 8'h00, 8'h00, 2'b11, 8'h00, 1'b1};
    vt[8] = '{2, 8'h80, 8'h80, 2'b00, 8'h00, 1'b1};
    vt[9] = '{1, 8'h03, 8'h05, 2'b01, 8'hFE, 1'b0};
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    req_op = '0;
    rsp_ready = 1'b0;
    #3 reset_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rsp_result", rsp_result, 0);
    chk("rst_rsp_zero", rsp_zero, 0);
    #2 reset_n = 1'b1;
    foreach (vt[k]) run_vec(vt[k]);

    reset_pulse();
    tick();
    for (int i = 0; i < N; i++) set_req(i, 8'(i), 8'h01, 2'b00);
    req_valid = '1;
    rsp_ready = 1'b1;
    acc_log.delete();
    rsp_log.delete();
    repeat (15) @(negedge clk);
    tick();
    req_valid = '0;
    chk("rr_accepts", acc_log.size(), 5);
    chk("rr_responses", rsp_log.size(), 5);
    for (int k = 0; k < acc_log.size(); k++) chk("rr_order", acc_log[k], k % 4);
    for (int k = 0; k < rsp_log.size(); k++) chk("rr_result", rsp_log[k], (k % 4) + 1);

    @(negedge clk);
    tick();
    rsp_ready = 1'b0;
    set_req(1, 8'hFF, 8'h01, 2'b00);
    req_valid = 4'b0010;
    @(negedge clk);
    chk("bp_accept", req_ready, 4'b0010);
    tick();
    set_req(0, 8'h33, 8'h11, 2'b00);
    req_valid = 4'b0001;
    @(negedge clk);
    chk("bp_exec_no_rsp", rsp_valid, 0);
    chk("bp_exec_ready", req_ready, 0);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) tick();
      if (k == 1) begin
        set_req(2, 8'h77, 8'h01, 2'b00);
        req_valid[2] = 1'b1;
      end
      if (k == 3) req_valid[2] = 1'b0;
      @(negedge clk);
      chk("bp_valid", rsp_valid, 1);
      chk("bp_result", rsp_result, 8'h00);
      chk("bp_zero", rsp_zero, 1);
      chk("bp_id", rsp_id, 1);
      chk("bp_ready_low", req_ready, 0);
    end
    tick();
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", rsp_valid, 1);
    tick();
    @(negedge clk);
    chk("bp_next_grant", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    chk("bp_drain_result", rsp_result, 8'h44);
    @(negedge clk);

    tick();
    set_req(3, 8'h12, 8'h34, 2'b00);
    req_valid = 4'b1000;
    @(negedge clk);
    chk("rst_mid_accept", req_ready, 4'b1000);
    tick();
    req_valid = '0;
    #2 reset_n = 1'b0;
    #1;
    chk("rst_mid_valid", rsp_valid, 0);
    chk("rst_mid_result", rsp_result, 0);
    chk("rst_mid_id", rsp_id, 0);
    @(negedge clk);
    #2 reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rst_mid_no_rsp", rsp_valid, 0);
    end
    tick();
    for (int i = 0; i < N; i++) set_req(i, 8'h20, 8'(i), 2'b11);
    req_valid = '1;
    @(negedge clk);
    chk("rst_mid_first_grant", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    repeat (3) @(negedge clk);

`ifdef ALU_SHARE_ARBITER_STATS_EN
    reset_pulse();
    for (int k = 0; k < 300; k++) run_vec('{3, 8'h01, 8'h01, 2'b00, 8'h02, 1'b0});
    chk("stats_req3", grant_cnt[31:24], 8'hFF);
    chk("stats_req0", grant_cnt[7:0], 8'h00);
    chk("stats_req1", grant_cnt[15:8], 8'h00);
    chk("stats_req2", grant_cnt[23:16], 8'h00);
    @(negedge clk);
`endif

    repeat (2) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one instance of the existing 8-bit `alu` (SrcA, SrcB, 2-bit ALUControl, ALUResult, Zero) between NREQ requesters.
- Round-robin arbitration; operands are captured in registers and the result is held in a response register.
- One operation is in flight at a time.
- Sits between requester engines and the ALU.

Parameters:
- NREQ, 4, number of requesters (2..8)
- IDW, $clog2(NREQ), requester-id width (derived; not overridden)

Ports:
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  per-requester accept; one-hot or zero
- req_a  in  NREQ*8  packed SrcA per requester; slice i belongs to requester i
- req_b  in  NREQ*8  packed SrcB per requester
- req_op  in  NREQ*2  packed ALUControl per requester: 00 add, 01 sub, 10 and, 11 or
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumer accept
- rsp_id  out  IDW  index of the requester that owns the response
- rsp_result  out  8  registered ALUResult
- rsp_zero  out  1  registered Zero

Behaviour:
- Reset (reset_n low, asynchronous):
  - state=IDLE; rr_ptr=NREQ-1, so requester 0 wins first.
  - All registers clear; req_ready=0, rsp_valid=0, rsp_id=0, rsp_result=0, rsp_zero=0.
- FSM states and transitions:
  - IDLE: if any req_valid, assert req_ready for the winner only, combinationally in this cycle. On the edge, capture winner a/b/op into op registers and winner id into id_q; rr_ptr<=winner; go to EXEC. If no req_valid, stay in IDLE.
  - EXEC: the ALU is driven only from the op registers. On the edge, rsp_result<=ALUResult, rsp_zero<=Zero, rsp_id<=id_q, rsp_valid<=1; go to RESP.
  - RESP: hold rsp_* stable while rsp_ready=0. On the edge with rsp_ready=1: rsp_valid<=0, go to IDLE.
- req_ready is 0 in EXEC and RESP.
- Handshakes:
  - Request transfer = req_valid[i] & req_ready[i].
  - Response transfer = rsp_valid & rsp_ready.
  - Requesters hold a/b/op stable while valid and not yet accepted.
- Latency: accept at cycle T; rsp_valid high from T+2. Minimum spacing between accepts is 3 cycles when rsp_ready is tied high.
- Round-robin rule:
  - Search from rr_ptr+1 upward, modulo NREQ; the first asserted req_valid wins.
  - A requester that was just granted has the lowest priority next time.
- Arithmetic is the ALU's own: 8-bit, add/sub wrap modulo 256, Zero = (result==0). The arbiter does not alter the result.
- Boundary conditions:
  - All requesters valid continuously: grants go 0,1,2,3,0,… .
  - A requester deasserting valid before it is granted: legal; it is simply not granted.
  - rsp_ready high in a cycle where rsp_valid is low: ignored.
  - reset_n asserted mid-operation: the in-flight op is dropped, no response is produced, and the state is the full reset state above.
  - Back-to-back: the IDLE cycle after a response is mandatory; no bypass.

Optional Feature:
- Macro: ALU_SHARE_ARBITER_STATS_EN.
- Defined:
  - Adds output port grant_cnt, NREQ*8 bits: per-requester 8-bit saturating counters.
  - A counter increments on each request transfer for that requester and saturates at 8'hFF.
  - Counters clear on reset.
- Undefined:
  - grant_cnt is absent, along with the counters.
  - All other behaviour is identical.

Decomposition:
- Package alu_pkg:
  - alu_op_t enum (ALU_ADD=2'b00, ALU_SUB=2'b01, ALU_AND=2'b10, ALU_OR=2'b11).
  - arb_state_t enum {IDLE, EXEC, RESP}.
  - ALU_W=8.
- Sub-module rr_arbiter: parameter N; inputs req[N] and ptr; output one-hot gnt[N] plus gnt_idx. Purely combinational.
- The top level instantiates rr_arbiter and the existing alu unchanged.

Test Plan:
- Single request: only req 0 valid, a=05, b=0A, op=00, rsp_ready=1 → req_ready[0] in the accept cycle; two cycles later rsp_valid=1, rsp_id=0, rsp_result=0F, rsp_zero=0.
- Subtract to zero: req 2, a=05, b=05, op=01 → rsp_result=00, rsp_zero=1, rsp_id=2.
- Round-robin fairness: all 4 requesters valid throughout, each with distinct operands (req i: a=i, b=01, op=00) → accept order 0,1,2,3,0; rsp_result order 01,02,03,04,01; never two req_ready bits high.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid, with req 1 (a=FF, b=01, op=00) → rsp stays 00 with zero=1 and stable; req_ready stays 0 throughout; response completes only when rsp_ready=1.
- Reset mid-operation: assert reset_n=0 during EXEC → rsp_valid=0 immediately (async); after release the next grant goes to requester 0.
- Stats (with ALU_SHARE_ARBITER_STATS_EN): 300 accepts to req 3 → grant_cnt slice 3 = FF; other slices = 00.
